// File: rtl/x_pulse_stretch.sv
// ============================================================================
// Module   : x_pulse_stretch
// Brief    : Retriggerable pulse stretcher with post-stretch holdoff guard and
//            a saturating counter of trigger cycles that were not accepted.
// Revision : 1.0
// ============================================================================
`default_nettype none

module x_pulse_stretch #(
    parameter int NBITS    = 4,
    parameter int MISSBITS = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                d,
    input  logic [NBITS-1:0]    length,
    input  logic [NBITS-1:0]    holdoff,
    input  logic                retrig_en,
    input  logic                missed_clr,
    output logic                q,
    output logic                busy,
    output logic [MISSBITS-1:0] missed
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_STRETCH = 2'd1,
        S_GUARD   = 2'd2
    } state_t;

    localparam logic [NBITS-1:0]    C_ONE  = NBITS'(1);
    localparam logic [MISSBITS-1:0] C_MONE = MISSBITS'(1);

    state_t              state_q, state_d;
    logic [NBITS-1:0]    cnt_q, cnt_d;
    logic [MISSBITS-1:0] missed_q, missed_d;
    logic                q_q, q_d;
    logic                busy_q, busy_d;
    logic                miss_ev;
    logic [NBITS-1:0]    len_m1;
    logic [NBITS-1:0]    hold_m1;

    // A zero length behaves as a one-cycle stretch.
    assign len_m1  = (length == '0) ? '0 : (length - C_ONE);
    assign hold_m1 = holdoff - C_ONE;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        miss_ev = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (d) begin
                    state_d = S_STRETCH;
                    cnt_d   = len_m1;
                end
            end
            S_STRETCH: begin
                if (d && retrig_en) begin
                    cnt_d = len_m1;
                end else begin
                    miss_ev = d;
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - C_ONE;
                    end else if (holdoff != '0) begin
                        state_d = S_GUARD;
                        cnt_d   = hold_m1;
                    end else begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                    end
                end
            end
            S_GUARD: begin
                miss_ev = d;
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - C_ONE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase

        // Clear has priority over a coincident miss; the count never wraps.
        if (missed_clr) begin
            missed_d = '0;
        end else if (miss_ev && (missed_q != '1)) begin
            missed_d = missed_q + C_MONE;
        end else begin
            missed_d = missed_q;
        end

        q_d    = (state_d == S_STRETCH);
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            missed_q <= '0;
            q_q      <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            missed_q <= missed_d;
            q_q      <= q_d;
            busy_q   <= busy_d;
        end
    end

    assign q      = q_q;
    assign busy   = busy_q;
    assign missed = missed_q;

endmodule

`default_nettype wire

// File: tb/tb_x_pulse_stretch.sv
// ============================================================================
// Module   : tb_x_pulse_stretch
// Brief    : Directed self-checking bench for x_pulse_stretch.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_x_pulse_stretch;

    logic       clk;
    logic       reset;
    logic       d;
    logic [3:0] length;
    logic [3:0] holdoff;
    logic       retrig_en;
    logic       missed_clr;
    logic       q;
    logic       busy;
    logic [7:0] missed;

    int total;
    int bad;

    x_pulse_stretch #(
        .NBITS    (4),
        .MISSBITS (8)
    ) u_dut (
        .clk        (clk),
        .reset      (reset),
        .d          (d),
        .length     (length),
        .holdoff    (holdoff),
        .retrig_en  (retrig_en),
        .missed_clr (missed_clr),
        .q          (q),
        .busy       (busy),
        .missed     (missed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [15:0] dv;
        logic [15:0] qv;
        int          hi;

        total      = 0;
        bad        = 0;
        reset      = 1'b1;
        d          = 1'b0;
        length     = 4'd4;
        holdoff    = 4'd0;
        retrig_en  = 1'b0;
        missed_clr = 1'b0;
        #2;
        chk("reset_q", 32'(q), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_missed", 32'(missed), 32'd0);
        tick();
        tick();
        reset = 1'b0;
        tick();

        // length=4: q high for the four samples after the accepting edge
        d = 1'b1;
        tick();
        d = 1'b0;
        chk("l4_q_first", 32'(q), 32'd1);
        chk("l4_busy_first", 32'(busy), 32'd1);
        hi = 1;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (q) hi++;
        end
        chk("l4_high_cycles", 32'(hi), 32'd4);
        chk("l4_busy_end", 32'(busy), 32'd0);
        chk("l4_missed", 32'(missed), 32'd0);

        // length=0 behaves as 1
        length = 4'd0;
        d      = 1'b1;
        tick();
        d = 1'b0;
        chk("l0_q_first", 32'(q), 32'd1);
        tick();
        chk("l0_q_second", 32'(q), 32'd0);

        // length=15
        length = 4'd15;
        d      = 1'b1;
        tick();
        d  = 1'b0;
        hi = (q) ? 1 : 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (q) hi++;
        end
        chk("l15_high_cycles", 32'(hi), 32'd15);

        // retrigger: d at t, t+2, t+4 with length=3
        length    = 4'd3;
        retrig_en = 1'b1;
        dv        = 16'b0000_0000_0001_0101;
        qv        = 16'b0000_0000_0111_1111;
        for (int i = 0; i < 9; i++) begin
            d = dv[i];
            tick();
            chk($sformatf("retrig_q_%0d", i), 32'(q), 32'(qv[i]));
        end
        d = 1'b0;
        chk("retrig_missed", 32'(missed), 32'd0);

        // same pattern without retrigger: t+2 missed, t+4 accepted in IDLE
        retrig_en = 1'b0;
        qv        = 16'b0000_0000_0111_0111;
        for (int i = 0; i < 9; i++) begin
            d = dv[i];
            tick();
            chk($sformatf("noretrig_q_%0d", i), 32'(q), 32'(qv[i]));
        end
        d = 1'b0;
        chk("noretrig_missed", 32'(missed), 32'd1);

        // clear, then length=2 holdoff=3 with d held high for 10 edges
        missed_clr = 1'b1;
        tick();
        missed_clr = 1'b0;
        chk("clr_missed", 32'(missed), 32'd0);
        length  = 4'd2;
        holdoff = 4'd3;
        qv      = 16'b0000_0000_1100_0011;
        for (int i = 0; i < 10; i++) begin
            d = 1'b1;
            tick();
            chk($sformatf("guard_q_%0d", i), 32'(q), 32'(qv[i]));
        end
        d = 1'b0;
        chk("guard_busy", 32'(busy), 32'd1);
        chk("guard_missed", 32'(missed), 32'd8);
        tick();
        chk("guard_busy_tail", 32'(busy), 32'd1);
        tick();
        chk("guard_busy_done", 32'(busy), 32'd0);

        // miss coincident with clear leaves zero
        d = 1'b1;
        tick();
        missed_clr = 1'b1;
        tick();
        missed_clr = 1'b0;
        d          = 1'b0;
        chk("clr_wins", 32'(missed), 32'd0);
        for (int i = 0; i < 8; i++) tick();
        chk("idle_again", 32'(busy), 32'd0);

        // saturation: length=15, no guard, d held high
        length  = 4'd15;
        holdoff = 4'd0;
        d       = 1'b1;
        for (int i = 0; i < 16; i++) tick();
        chk("sat_partial", 32'(missed), 32'd15);
        for (int i = 0; i < 320; i++) tick();
        chk("sat_full", 32'(missed), 32'd255);
        for (int i = 0; i < 20; i++) tick();
        chk("sat_hold", 32'(missed), 32'd255);

        // asynchronous reset mid-stretch
        d = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        d = 1'b1;
        tick();
        d = 1'b0;
        tick();
        chk("pre_reset_q", 32'(q), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("async_q", 32'(q), 32'd0);
        chk("async_busy", 32'(busy), 32'd0);
        chk("async_missed", 32'(missed), 32'd0);
        d = 1'b1;
        tick();
        tick();
        chk("reset_ignores_d_q", 32'(q), 32'd0);
        chk("reset_ignores_d_missed", 32'(missed), 32'd0);
        reset = 1'b0;
        tick();
        chk("post_reset_accept", 32'(q), 32'd1);
        d = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
